// File: rtl/gray_monitor.sv
// Tracks a 3-bit Gray-coded upstream counter: decodes each accepted sample,
// flags +1 steps, repeats and wraps, and latches an error on illegal sequences.
module gray_monitor #(
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [2:0]        GrayIn,
  input  logic              Clear,
  output logic [2:0]        Bin,
  output logic              Step,
  output logic              Hold,
  output logic              Overflow,
  output logic [WRAP_W-1:0] WrapCnt,
  output logic              Error,
  output logic              Locked
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Declaration initialisers give the reset values from time zero.
  state_t            state     = IDLE;
  logic [2:0]        bin_q     = '0;
  logic              step_q    = 1'b0;
  logic              hold_q    = 1'b0;
  logic              ovf_q     = 1'b0;
  logic [WRAP_W-1:0] wrap_q    = '0;
  logic              err_q     = 1'b0;

  logic [2:0] dec;
  logic [2:0] bin_inc;

  always_comb begin
    dec[2]  = GrayIn[2];
    dec[1]  = GrayIn[2] ^ GrayIn[1];
    dec[0]  = GrayIn[2] ^ GrayIn[1] ^ GrayIn[0];
    bin_inc = bin_q + 3'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      bin_q  <= '0;
      step_q <= 1'b0;
      hold_q <= 1'b0;
      ovf_q  <= 1'b0;
      wrap_q <= '0;
      err_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      hold_q <= 1'b0;
      if (Clear) begin
        state  <= IDLE;
        ovf_q  <= 1'b0;
        wrap_q <= '0;
        err_q  <= 1'b0;
      end else if (Valid) begin
        case (state)
          IDLE: begin
            bin_q <= dec;
            state <= TRACK;
          end
          TRACK: begin
            if (dec == bin_q) begin
              hold_q <= 1'b1;
            end else if (dec == bin_inc) begin
              bin_q  <= dec;
              step_q <= 1'b1;
              if (bin_q == 3'd7) begin
                ovf_q <= 1'b1;
                if (wrap_q != '1)
                  wrap_q <= wrap_q + WRAP_W'(1);
              end
            end else begin
              err_q <= 1'b1;
              state <= ERROR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Bin      = bin_q;
  assign Step     = step_q;
  assign Hold     = hold_q;
  assign Overflow = ovf_q;
  assign WrapCnt  = wrap_q;
  assign Error    = err_q;
  assign Locked   = (state == TRACK);

endmodule
